// File: rtl/online_softmax_accum.sv
`default_nettype none
// ============================================================================
// Module  : online_softmax_accum
// Brief   : Streaming online-softmax accumulator (running max m, denominator l,
//           weighted V sum o[]). Optional output normalization: NORMALIZE_EN.
// Revision: 1.0 - initial release
// ============================================================================

`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 4
`endif
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 4
`endif

module online_softmax_accum #(
    parameter int SEQ_LEN = `MAX_SEQ_LENGTH,
    parameter int EMB_DIM = `MAX_EMBEDDING_DIM,
    parameter int S_W     = 12,
    parameter int S_FRAC  = 4,
    parameter int V_W     = 8,
    parameter int ACC_W   = 32,
    parameter int L_W     = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vld_in,
    output logic                     rdy_out,
    input  logic [S_W-1:0]           s_in,
    input  logic [EMB_DIM*V_W-1:0]   v_in,
    output logic                     vld_out,
    input  logic                     rdy_in,
    output logic [EMB_DIM*ACC_W-1:0] o_out,
    output logic [L_W-1:0]           l_out
);

    localparam int CNT_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int D_W   = S_W + 1;
    localparam int T_W   = S_W + 3;
    localparam int P_W   = ACC_W + 17;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(SEQ_LEN - 1);
    localparam logic [L_W-1:0]   C_ONE  = L_W'(32768);

`ifdef NORMALIZE_EN
    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_NORM  = 2'd1,
        ST_OUT   = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_OUT   = 1'b1
    } state_t;
`endif

    // Piecewise-linear 2^-(d*log2e) approximation, unsigned Q1.15 result.
    function automatic logic [15:0] pexp(input logic [D_W-1:0] d);
        logic [T_W-1:0] t;
        logic [T_W-1:0] k;
        logic [16:0]    base;
        t    = T_W'(d) + T_W'(d >> 1) - T_W'(d >> 4);
        k    = t >> S_FRAC;
        base = 17'd32768 - ((17'(t[S_FRAC-1:0]) << (15 - S_FRAC)) >> 1);
        if (k >= T_W'(16))
            pexp = 16'd0;
        else
            pexp = 16'(base >> k[3:0]);
    endfunction

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [S_W-1:0]   r_m;
    logic [L_W-1:0]          r_l;
    logic signed [ACC_W-1:0] r_o     [EMB_DIM];
    logic signed [ACC_W-1:0] r_o_out [EMB_DIM];
    logic [L_W-1:0]          r_l_out;

    logic                    w_accept;
    logic                    w_first;
    logic                    w_last;
    logic                    w_gt;
    logic signed [D_W-1:0]   w_s_ext;
    logic signed [D_W-1:0]   w_m_ext;
    logic [D_W-1:0]          w_d;
    logic [15:0]             w_wt;
    logic [L_W+15:0]         w_l_prod;
    logic [L_W-1:0]          w_l_next;
    logic signed [ACC_W-1:0] w_o_next [EMB_DIM];

`ifdef NORMALIZE_EN
    logic [L_W:0]            r_rem;
    logic [31:0]             r_q;
    logic [5:0]              r_div_cnt;
    logic [L_W+1:0]          w_rem_sh;
    logic [L_W+1:0]          w_rem_sub;
    logic                    w_rem_ge;
    logic                    w_div_done;
    logic signed [ACC_W-1:0] w_o_norm [EMB_DIM];

    assign w_rem_sh   = {r_rem, 1'b0};
    assign w_rem_sub  = w_rem_sh - {2'b00, r_l};
    assign w_rem_ge   = (w_rem_sh >= {2'b00, r_l});
    assign w_div_done = r_div_cnt[5];
`endif

    assign w_accept = vld_in && (r_state == ST_ACCUM);
    assign w_first  = (r_cnt == '0);
    assign w_last   = (r_cnt == C_LAST);
    assign w_gt     = $signed(s_in) > r_m;
    assign w_s_ext  = D_W'($signed(s_in));
    assign w_m_ext  = D_W'(r_m);
    assign w_d      = w_gt ? D_W'(w_s_ext - w_m_ext) : D_W'(w_m_ext - w_s_ext);
    assign w_wt     = pexp(w_d);
    assign w_l_prod = (L_W+16)'(r_l) * (L_W+16)'(w_wt);

    always_comb begin
        w_l_next = r_l + L_W'(w_wt);
        if (w_first)
            w_l_next = C_ONE;
        else if (w_gt)
            w_l_next = L_W'(w_l_prod >> 15) + C_ONE;
    end

    generate
        for (genvar i = 0; i < EMB_DIM; i++) begin : g_lane
            logic signed [ACC_W-1:0] w_v_ext;
            logic signed [ACC_W-1:0] w_v_sh;
            logic signed [P_W-1:0]   w_o_prod;
            logic signed [ACC_W-1:0] w_o_scaled;
            logic signed [ACC_W-1:0] w_pv;

            assign w_v_ext    = ACC_W'($signed(v_in[i*V_W +: V_W]));
            assign w_v_sh     = w_v_ext <<< 15;
            assign w_o_prod   = P_W'(r_o[i]) * $signed({{(P_W-16){1'b0}}, w_wt});
            assign w_o_scaled = ACC_W'(w_o_prod >>> 15);
            assign w_pv       = w_v_ext * $signed({{(ACC_W-16){1'b0}}, w_wt});

            assign w_o_next[i] = w_first ? w_v_sh :
                                 w_gt    ? (w_o_scaled + w_v_sh) :
                                           (r_o[i] + w_pv);

            assign o_out[i*ACC_W +: ACC_W] = r_o_out[i];

`ifdef NORMALIZE_EN
            logic signed [ACC_W+32:0] w_n_prod;
            assign w_n_prod    = (ACC_W+33)'(r_o[i]) * $signed({{(ACC_W+1){1'b0}}, r_q});
            assign w_o_norm[i] = ACC_W'(w_n_prod >>> 46);
`endif
        end
    endgenerate

    assign l_out = r_l_out;

    always_comb begin
        w_state_next = r_state;
        rdy_out      = 1'b0;
        vld_out      = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                rdy_out = 1'b1;
                if (vld_in && w_last)
`ifdef NORMALIZE_EN
                    w_state_next = ST_NORM;
`else
                    w_state_next = ST_OUT;
`endif
            end
`ifdef NORMALIZE_EN
            ST_NORM: begin
                if (w_div_done)
                    w_state_next = ST_OUT;
            end
`endif
            ST_OUT: begin
                vld_out = 1'b1;
                if (rdy_in)
                    w_state_next = ST_ACCUM;
            end
            default: w_state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
            r_cnt   <= '0;
            r_m     <= '0;
            r_l     <= '0;
            r_l_out <= '0;
            for (int i = 0; i < EMB_DIM; i++) begin
                r_o[i]     <= '0;
                r_o_out[i] <= '0;
            end
`ifdef NORMALIZE_EN
            r_rem     <= '0;
            r_q       <= '0;
            r_div_cnt <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
                r_m   <= (w_first || w_gt) ? $signed(s_in) : r_m;
                r_l   <= w_l_next;
                for (int i = 0; i < EMB_DIM; i++)
                    r_o[i] <= w_o_next[i];
                if (w_last) begin
                    r_l_out <= w_l_next;
`ifdef NORMALIZE_EN
                    // 2^46 / l: the top 32 dividend bits are 2^14, always below l.
                    r_rem     <= (L_W+1)'(17'd16384);
                    r_q       <= '0;
                    r_div_cnt <= '0;
`else
                    for (int i = 0; i < EMB_DIM; i++)
                        r_o_out[i] <= w_o_next[i];
`endif
                end
            end
`ifdef NORMALIZE_EN
            if (r_state == ST_NORM) begin
                if (!w_div_done) begin
                    r_rem     <= w_rem_ge ? w_rem_sub[L_W:0] : w_rem_sh[L_W:0];
                    r_q       <= {r_q[30:0], w_rem_ge};
                    r_div_cnt <= r_div_cnt + 6'd1;
                end else begin
                    for (int i = 0; i < EMB_DIM; i++)
                        r_o_out[i] <= w_o_norm[i];
                end
            end
`endif
        end
    end

endmodule

`default_nettype wire
